// File: rtl/div_unit_pkg.sv
// Shared definitions for the RV32M divider: ALU operation codes and divider FSM states.
package div_unit_pkg;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_DIV  = 5'd10;
  localparam logic [4:0] ALU_DIVU = 5'd11;
  localparam logic [4:0] ALU_REM  = 5'd12;
  localparam logic [4:0] ALU_REMU = 5'd13;

  typedef enum logic [1:0] {
    DIV_S_IDLE = 2'd0,
    DIV_S_CALC = 2'd1,
    DIV_S_FIX  = 2'd2,
    DIV_S_DONE = 2'd3
  } div_state_e;

  function automatic logic is_div_op(input logic [4:0] code);
    logic hit;
    case (code)
      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: hit = 1'b1;
      default:                              hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract division step on unsigned magnitudes.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN:0]   rem_out,
  output logic [XLEN-1:0] quo_out
);
  logic [XLEN:0] shifted_s;
  logic [XLEN:0] diff_s;
  logic          ge_s;

  assign shifted_s = {rem_in[XLEN-1:0], quo_in[XLEN-1]};
  assign diff_s    = shifted_s - {1'b0, divisor};
  // a set top bit means the shifted value is already past any XLEN-bit divisor
  assign ge_s      = rem_in[XLEN] | (shifted_s >= {1'b0, divisor});

  // Keep the difference and set the quotient bit when the subtraction fits
  always_comb begin
    rem_out = shifted_s;
    quo_out = {quo_in[XLEN-2:0], 1'b0};
    if (ge_s) begin
      rem_out    = diff_s;
      quo_out[0] = 1'b1;
    end else begin
      rem_out    = shifted_s;
      quo_out[0] = 1'b0;
    end
  end

endmodule

// File: rtl/div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU) with fixed latency and a stall request.
// Optional last-result cache enabled by defining DIV_RESULT_CACHE_EN.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            start,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e state_r, state_n;
  logic busy_r, done_r, is_rem_r, neg_q_r, neg_r_r;
  logic [XLEN-1:0] result_r, quo_r, divisor_r;
  logic [XLEN:0] rem_r;
  logic [CNT_W-1:0] cnt_r;

  logic op_signed_s, op_rem_s, accept_s, div_zero_s, ovf_s, hit_s, special_s;
  logic rs1_neg_s, rs2_neg_s;
  logic [XLEN-1:0] rs1_mag_s, rs2_mag_s, special_res_s, quo_fix_s, rem_fix_s;
  logic [XLEN:0] step_rem_s;
  logic [XLEN-1:0] step_quo_s;

  assign op_signed_s = (op == ALU_DIV) || (op == ALU_REM);
  assign op_rem_s    = (op == ALU_REM) || (op == ALU_REMU);
  assign accept_s    = (state_r == DIV_S_IDLE) && start && !flush && is_div_op(op);
  assign div_zero_s  = (rs2 == ZERO);
  assign ovf_s       = op_signed_s && (rs1 == INT_MIN) && (rs2 == ALL_ONES);
  assign special_s   = div_zero_s || ovf_s || hit_s;
  assign rs1_neg_s   = op_signed_s && rs1[XLEN-1];
  assign rs2_neg_s   = op_signed_s && rs2[XLEN-1];
  assign rs1_mag_s   = rs1_neg_s ? (ZERO - rs1) : rs1;
  assign rs2_mag_s   = rs2_neg_s ? (ZERO - rs2) : rs2;
  assign quo_fix_s   = neg_q_r ? (ZERO - quo_r) : quo_r;
  assign rem_fix_s   = neg_r_r ? (ZERO - rem_r[XLEN-1:0]) : rem_r[XLEN-1:0];

  div_step #(.XLEN(XLEN)) u_step (
    .rem_in  (rem_r),
    .quo_in  (quo_r),
    .divisor (divisor_r),
    .rem_out (step_rem_s),
    .quo_out (step_quo_s)
  );

`ifdef DIV_RESULT_CACHE_EN
  logic            cache_valid_r, cache_signed_r, op_signed_r;
  logic [XLEN-1:0] cache_rs1_r, cache_rs2_r, cache_quo_r, cache_rem_r, op_rs1_r, op_rs2_r;

  assign hit_s = cache_valid_r && (rs1 == cache_rs1_r) && (rs2 == cache_rs2_r)
                 && (op_signed_s == cache_signed_r);

  // Remember raw operands of the op in flight and capture them with its results on completion
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cache_valid_r  <= 1'b0;
      cache_signed_r <= 1'b0;
      op_signed_r    <= 1'b0;
      cache_rs1_r    <= ZERO;
      cache_rs2_r    <= ZERO;
      cache_quo_r    <= ZERO;
      cache_rem_r    <= ZERO;
      op_rs1_r       <= ZERO;
      op_rs2_r       <= ZERO;
    end else begin
      if (accept_s) begin
        op_rs1_r    <= rs1;
        op_rs2_r    <= rs2;
        op_signed_r <= op_signed_s;
      end
      if ((state_r == DIV_S_FIX) && !flush) begin
        cache_valid_r  <= 1'b1;
        cache_rs1_r    <= op_rs1_r;
        cache_rs2_r    <= op_rs2_r;
        cache_signed_r <= op_signed_r;
        cache_quo_r    <= quo_fix_s;
        cache_rem_r    <= rem_fix_s;
      end
    end
  end
`else
  assign hit_s = 1'b0;
`endif

  // Result for operations that complete without iterating
  always_comb begin
    special_res_s = ZERO;
    if (div_zero_s) begin
      special_res_s = op_rem_s ? rs1 : ALL_ONES;
    end else if (ovf_s) begin
      special_res_s = op_rem_s ? ZERO : INT_MIN;
    end else begin
`ifdef DIV_RESULT_CACHE_EN
      special_res_s = op_rem_s ? cache_rem_r : cache_quo_r;
`else
      special_res_s = ZERO;
`endif
    end
  end

  // Next-state logic; flush overrides every state
  always_comb begin
    state_n = state_r;
    if (flush) begin
      state_n = DIV_S_IDLE;
    end else begin
      case (state_r)
        DIV_S_IDLE: if (accept_s) state_n = special_s ? DIV_S_DONE : DIV_S_CALC;
                    else          state_n = DIV_S_IDLE;
        DIV_S_CALC: if (cnt_r == CNT_W'(1)) state_n = DIV_S_FIX;
                    else                    state_n = DIV_S_CALC;
        DIV_S_FIX:  state_n = DIV_S_DONE;
        DIV_S_DONE: state_n = DIV_S_IDLE;
        default:    state_n = DIV_S_IDLE;
      endcase
    end
  end

  // State, registered outputs and the iterating datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= DIV_S_IDLE;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      result_r  <= ZERO;
      rem_r     <= {(XLEN+1){1'b0}};
      quo_r     <= ZERO;
      divisor_r <= ZERO;
      cnt_r     <= {CNT_W{1'b0}};
      is_rem_r  <= 1'b0;
      neg_q_r   <= 1'b0;
      neg_r_r   <= 1'b0;
    end else begin
      state_r <= state_n;
      busy_r  <= (state_n != DIV_S_IDLE);
      done_r  <= (state_n == DIV_S_DONE);
      if (accept_s) begin
        is_rem_r  <= op_rem_s;
        neg_q_r   <= rs1_neg_s ^ rs2_neg_s;
        neg_r_r   <= rs1_neg_s;
        rem_r     <= {(XLEN+1){1'b0}};
        quo_r     <= rs1_mag_s;
        divisor_r <= rs2_mag_s;
        cnt_r     <= CNT_W'(XLEN);
        if (special_s) result_r <= special_res_s;
      end else if ((state_r == DIV_S_CALC) && !flush) begin
        rem_r <= step_rem_s;
        quo_r <= step_quo_s;
        cnt_r <= cnt_r - CNT_W'(1);
      end else if ((state_r == DIV_S_FIX) && !flush) begin
        result_r <= is_rem_r ? rem_fix_s : quo_fix_s;
      end
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: cycle-level behavioural model plus directed vectors.
module tb_div_unit;
  import div_unit_pkg::*;

  localparam int LAT = 34;
`ifdef DIV_RESULT_CACHE_EN
  localparam int HIT_LAT = 1;
`else
  localparam int HIT_LAT = 34;
`endif

  logic clk = 1'b0, rst_n, flush, start, busy, done;
  logic [4:0] op;
  logic [31:0] rs1, rs2, result;
  int total = 0, bad = 0;
  bit chk_en = 1'b0;

  div_unit dut (.clk(clk), .rst_n(rst_n), .flush(flush), .start(start), .op(op),
                .rs1(rs1), .rs2(rs2), .busy(busy), .done(done), .result(result));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit tb_is_div(input logic [4:0] o);
    return (o == ALU_DIV) || (o == ALU_DIVU) || (o == ALU_REM) || (o == ALU_REMU);
  endfunction

  function automatic bit tb_signed(input logic [4:0] o);
    return (o == ALU_DIV) || (o == ALU_REM);
  endfunction

  // RISC-V M-extension arithmetic semantics
  function automatic logic [31:0] ref_div(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    bit want_rem;
    want_rem = (o == ALU_REM) || (o == ALU_REMU);
    sa = a; sb = b;
    if (b == 32'd0) return want_rem ? a : 32'hFFFF_FFFF;
    if (tb_signed(o)) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return want_rem ? 32'd0 : 32'h8000_0000;
      return want_rem ? 32'(sa % sb) : 32'(sa / sb);
    end
    return want_rem ? (a % b) : (a / b);
  endfunction

  // Behavioural model: state of the expected outputs, advanced each rising edge
  bit m_act, m_busy, m_done, c_valid, c_sgn, m_sgn;
  int m_k, m_lat;
  logic [31:0] m_result, m_pend, m_a, m_b, c_a, c_b;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_act <= 1'b0; m_busy <= 1'b0; m_done <= 1'b0; m_result <= 32'd0; c_valid <= 1'b0;
    end else if (flush) begin
      m_act <= 1'b0; m_busy <= 1'b0; m_done <= 1'b0;
    end else if (m_act) begin
      if (m_done) begin
        m_act <= 1'b0; m_busy <= 1'b0; m_done <= 1'b0;
      end else begin
        m_k <= m_k + 1;
        if (m_k + 1 == m_lat) begin
          m_done <= 1'b1;
          m_result <= m_pend;
          c_valid <= 1'b1; c_a <= m_a; c_b <= m_b; c_sgn <= m_sgn;
        end
      end
    end else if (start && tb_is_div(op)) begin
      automatic bit sp = (rs2 == 32'd0) ||
                         (tb_signed(op) && rs1 == 32'h8000_0000 && rs2 == 32'hFFFF_FFFF);
`ifdef DIV_RESULT_CACHE_EN
      sp = sp || (c_valid && c_a == rs1 && c_b == rs2 && c_sgn == tb_signed(op));
`endif
      m_pend <= ref_div(op, rs1, rs2);
      m_a <= rs1; m_b <= rs2; m_sgn <= tb_signed(op);
      m_lat <= sp ? 1 : LAT;
      m_k <= 1; m_act <= 1'b1; m_busy <= 1'b1; m_done <= sp;
      if (sp) m_result <= ref_div(op, rs1, rs2);
    end
  end

  // Compare process: busy/done every cycle, result whenever it is meant to be stable
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_busy", {31'd0, busy}, {31'd0, m_busy});
      chk("model_done", {31'd0, done}, {31'd0, m_done});
      if (!m_busy || m_done) chk("model_result", result, m_result);
    end
  end

  // Drive one op in the current cycle (cycle 0) and wait for done; exp_lat<0 skips latency check
  task automatic run_op(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_r, input int exp_lat, input string name);
    int n;
    bit seen;
    start = 1'b1; op = o; rs1 = a; rs2 = b;
    @(posedge clk); #1; start = 1'b0;
    n = 1; seen = 1'b0;
    @(negedge clk);
    chk({"busy_c1_", name}, {31'd0, busy}, 32'd1);
    while (!seen && n <= 40) begin
      if (done) seen = 1'b1;
      else begin @(posedge clk); #1; n++; @(negedge clk); end
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL timeout_%s: got no done expected done", name);
    end else begin
      if (exp_lat > 0) chk({"lat_", name}, 32'(n), 32'(exp_lat));
      chk({"res_", name}, result, exp_r);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int n, dones;
    logic [4:0] rops [4];
    rops[0] = ALU_DIV; rops[1] = ALU_DIVU; rops[2] = ALU_REM; rops[3] = ALU_REMU;
    rst_n = 1'b0; flush = 1'b0; start = 1'b0; op = ALU_ADD; rs1 = 32'd0; rs2 = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    rst_n = 1'b1; chk_en = 1'b1;

    // Pin the arithmetic model with hand-computed values
    chk("pin_divu", ref_div(ALU_DIVU, 32'd100, 32'd7), 32'd14);
    chk("pin_rem_neg", ref_div(ALU_REM, 32'hFFFF_FFEC, 32'd3), 32'hFFFF_FFFE);
    chk("pin_div_neg", ref_div(ALU_DIV, 32'd7, 32'hFFFF_FFFE), 32'hFFFF_FFFD);
    chk("pin_ovf", ref_div(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);

    @(posedge clk); #1;
    run_op(ALU_DIVU, 32'd100, 32'd7, 32'd14, LAT, "divu_100_7");
    run_op(ALU_REMU, 32'd100, 32'd7, 32'd2, HIT_LAT, "remu_100_7");
    run_op(ALU_DIV, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, LAT, "div_m20_3");
    run_op(ALU_REM, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, HIT_LAT, "rem_m20_3");
    run_op(ALU_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "div_5_0");
    run_op(ALU_REMU, 32'd5, 32'd0, 32'd5, 1, "remu_5_0");
    run_op(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
    run_op(ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "rem_ovf");
    run_op(ALU_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, LAT, "divu_max_1");
    run_op(ALU_REMU, 32'd6, 32'd9, 32'd6, LAT, "remu_small");

    // Flush in cycle 10 aborts with no done and leaves the result alone
    start = 1'b1; op = ALU_DIVU; rs1 = 32'd1000; rs2 = 32'd3;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); if (done) dones++;
    end
    chk("flush_no_done", 32'(dones), 32'd0);
    chk("flush_result", result, 32'd6);
    @(posedge clk); #1;
    run_op(ALU_DIVU, 32'd1000, 32'd3, 32'd333, LAT, "divu_after_flush");

    // start held high with changing operands: only the first op is computed
    start = 1'b1; op = ALU_DIVU; rs1 = 32'd50; rs2 = 32'd5;
    @(posedge clk); #1; rs1 = 32'd77; rs2 = 32'd0;
    n = 1;
    @(negedge clk);
    while (!done && n <= 40) begin @(posedge clk); #1; n++; @(negedge clk); end
    start = 1'b0;
    chk("held_lat", 32'(n), 32'(LAT));
    chk("held_res", result, 32'd10);
    @(posedge clk); #1;
    chk("held_busy_after", {31'd0, busy}, 32'd0);

    // Non-divide op never raises busy
    start = 1'b1; op = ALU_ADD; rs1 = 32'd3; rs2 = 32'd4;
    repeat (3) begin @(posedge clk); #1; end
    start = 1'b0;
    chk("add_busy", {31'd0, busy}, 32'd0);

    // Reset mid-CALC clears every output
    start = 1'b1; op = ALU_DIVU; rs1 = 32'd1000; rs2 = 32'd3;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_done", {31'd0, done}, 32'd0);
    chk("rst_mid_result", result, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(ALU_DIV, 32'd100, 32'd7, 32'd14, LAT, "div_100_7");
    run_op(ALU_REM, 32'd100, 32'd7, 32'd2, HIT_LAT, "rem_100_7");

    for (int i = 0; i < 6; i++) begin
      logic [4:0] o;
      logic [31:0] a, b;
      o = rops[i % 4];
      a = $urandom;
      b = (i == 5) ? $urandom : 32'($urandom_range(1, 5000));
      run_op(o, a, b, ref_div(o, a, b), -1, "rand");
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
